riscv_muldiv: RTL



---
 rtl/riscv_muldiv_pkg.sv | 20 ++
 rtl/riscv_muldiv_signfix.sv | 42 ++++
 rtl/riscv_muldiv.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and the datapath width.
package riscv_muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/riscv_muldiv_signfix.sv
// Sign handling around the magnitude datapath: operand absolute values at
// capture time, and conditional negation of product/quotient/remainder at load.
module riscv_muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              neg_a_i,
  input  logic              neg_b_i,
  input  logic [2*XLEN-1:0] product_i,
  input  logic [XLEN-1:0]   quot_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic              sign_a,
  output logic              sign_b,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic [2*XLEN-1:0] product_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
);
  import riscv_muldiv_pkg::*;

  logic a_signed;
  logic b_signed;

  // MULHSU is the only op where the two operands differ in signedness.
  assign a_signed = !(funct3 == F3_MULHU || funct3 == F3_DIVU || funct3 == F3_REMU);
  assign b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                    (funct3 == F3_DIV) || (funct3 == F3_REM);

  assign sign_a = a_signed & a[XLEN-1];
  assign sign_b = b_signed & b[XLEN-1];
  assign abs_a  = sign_a ? -a : a;
  assign abs_b  = sign_b ? -b : b;

  // Remainder follows the dividend's sign so division truncates toward zero.
  assign product_o = (neg_a_i ^ neg_b_i) ? -product_i : product_i;
  assign quot_o    = (neg_a_i ^ neg_b_i) ? -quot_i : quot_i;
  assign rem_o     = neg_a_i ? -rem_i : rem_i;

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: fixed 32-cycle shift-add multiply or
// restoring divide on magnitudes, with sign fix-up and special cases at load.
module riscv_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import riscv_muldiv_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic            dz_q, dz_d, ovf_q, ovf_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] load_val;

  riscv_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .neg_a_i   (neg_a_q),
    .neg_b_i   (neg_b_q),
    .product_i ({step_hi, step_lo}),
    .quot_i    (step_lo),
    .rem_i     (step_hi),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .product_o (prod_fix),
    .quot_o    (quot_fix),
    .rem_o     (rem_fix)
  );

  // hi/lo double as {accumulator, multiplier} or {remainder, dividend->quotient}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (f3_q[2]) begin
      step_hi = div_ok ? div_diff : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    // A zero divisor naturally leaves |a| in the remainder, so REM/REMU need no override.
    case (f3_q)
      F3_MUL:                      load_val = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: load_val = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             load_val = dz_q ? ALL_ONES : (ovf_q ? INT_MIN : quot_fix);
      default:                     load_val = ovf_q ? {XLEN{1'b0}} : rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          f3_d    = funct3;
          neg_a_d = sign_a;
          neg_b_d = sign_b;
          dz_d    = (b == '0);
          ovf_d   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (a == INT_MIN) && (b == ALL_ONES);
          hi_d    = '0;
          lo_d    = funct3[2] ? abs_a : abs_b;
          opnd_d  = funct3[2] ? abs_b : abs_a;
        end
      end
      S_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = load_val;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
